// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with registered count-derived status flags
module sync_fifo #(
  parameter int DBITS = 8,
  parameter int SIZE = 4,
  parameter int AMARGIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [DBITS-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam int DEPTH = 2 ** SIZE;
  logic [DBITS-1:0] mem [DEPTH];
  logic [SIZE-1:0] rptr, wptr;
  logic [SIZE:0] count;
  logic do_wr, do_rd;
  always_comb begin
    do_wr = wr && !full;
    do_rd = rd && !empty;
    dout = mem[rptr];
    full = count == (SIZE+1)'(DEPTH);
    empty = count == '0;
    half_full = count >= (SIZE+1)'(DEPTH / 2);
    almost_full = count >= (SIZE+1)'(DEPTH - AMARGIN);
    almost_empty = count <= (SIZE+1)'(AMARGIN);
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= (do_wr && !do_rd) ? count + 1'b1 : (do_rd && !do_wr) ? count - 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo at DEPTH=16, AMARGIN=4
module tb_sync_fifo;
  logic clk = 0;
  logic reset = 1;
  logic [7:0] din = '0;
  logic wr = 0;
  logic rd = 0;
  logic [7:0] dout;
  logic full, empty, half_full, almost_full, almost_empty;
  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];

  sync_fifo #(.DBITS(8), .SIZE(4), .AMARGIN(4)) dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd), .dout(dout),
    .full(full), .empty(empty), .half_full(half_full),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_flags(input int n);
    return {n == 16, n == 0, n >= 8, n >= 12, n <= 4};
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_flags"}, {full, empty, half_full, almost_full, almost_empty}, exp_flags(q.size()));
    if (q.size() > 0) check({tag, "_dout"}, dout, q[0]);
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input string tag);
    int n;
    n = q.size();
    wr = w;
    rd = r;
    din = d;
    if (r && n > 0) check({tag, "_pop"}, dout, q.pop_front());
    if (w && n < 16) q.push_back(d);
    @(posedge clk);
    #1;
    wr = 0;
    rd = 0;
    check_state(tag);
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d, input string tag);
    reset = 1;
    wr = w;
    din = d;
    @(posedge clk);
    #1;
    reset = 0;
    wr = 0;
    q.delete();
    check_state(tag);
  endtask

  initial begin
    do_reset(0, 8'h00, "reset");
    cycle(0, 0, 8'h00, "idle");
    cycle(1, 0, 8'h11, "w11");
    cycle(1, 0, 8'h22, "w22");
    cycle(1, 0, 8'h33, "w33");
    check("three_dout", dout, 8'h11);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, "pop3");
    check("three_empty", empty, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), "fill16");
    check("full_set", full, 1'b1);
    cycle(1, 0, 8'hFF, "drop_ff");
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00, "drain16");
    cycle(0, 1, 8'h00, "pop_empty");
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i), "fill5");
    for (int i = 0; i < 20; i++) cycle(1, 1, 8'hAA, "wrap");
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00, "drain_aa");
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h80 + i), "refill");
    cycle(1, 1, 8'h77, "full_wr_rd");
    check("full_wr_rd_full", full, 1'b0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00, "drain15");
    cycle(1, 1, 8'h55, "empty_wr_rd");
    check("empty_wr_rd_dout", dout, 8'h55);
    cycle(0, 1, 8'h00, "pop55");
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'(8'hC0 + i), "fill10");
    do_reset(1, 8'hEE, "reset_wr");
    check("reset_wr_empty", empty, 1'b1);
    cycle(1, 0, 8'h99, "w99");
    check("w99_dout", dout, 8'h99);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DBITS, default 8: data word width in bits.
REQ-002 SHALL have parameter SIZE, default 4: log2 of depth; DEPTH = 2**SIZE entries.
REQ-003 SHALL have parameter AMARGIN, default 4: almost-full/almost-empty threshold in entries, 1 <= AMARGIN < DEPTH/2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  DBITS  write data.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read (pop) request.
REQ-009 dout  output  DBITS  head-of-queue data (show-ahead).
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 half_full  output  1  count >= DEPTH/2.
REQ-013 almost_full  output  1  count >= DEPTH-AMARGIN.
REQ-014 almost_empty  output  1  count <= AMARGIN.

Function
REQ-015 SHALL store up to DEPTH words in order; circular buffer with SIZE-bit read/write pointers wrapping DEPTH-1 -> 0, plus a (SIZE+1)-bit occupancy count.
REQ-016 SHALL accept a write on a rising edge when wr=1 and full=0: mem[wptr] <= din, wptr+1.
REQ-017 SHALL perform a pop on a rising edge when rd=1 and empty=0: rptr+1.
REQ-018 SHALL ignore wr when full=1 (data dropped, no state change) and rd when empty=1; no error flag.
REQ-019 Simultaneous wr and rd, both accepted: count unchanged, both pointers advance.
REQ-020 wr=1, rd=1 while empty: write only, count becomes 1.
REQ-021 wr=1, rd=1 while full: pop only, write dropped, count becomes DEPTH-1.
REQ-022 dout SHALL combinationally equal mem[rptr]; valid whenever empty=0, with no read latency; the popped word is the one on dout in the cycle rd is sampled.
REQ-023 dout SHALL be don't-care while empty=1.
REQ-024 All status flags SHALL be decoded from the registered count only; they change the cycle after the accepted access and have no combinational path from wr/rd.
REQ-025 Written data SHALL be visible on dout the cycle after the write when the FIFO was empty (no bypass from din).
REQ-026 Implementation SHALL use inferred memory without reset of contents.

Reset
REQ-027 reset=1 at a rising edge SHALL clear rptr, wptr, count to 0, taking priority over wr/rd in the same cycle.
REQ-028 After reset: empty=1, almost_empty=1, full=0, half_full=0, almost_full=0; dout don't-care.
REQ-029 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.

Verification (DBITS=8, SIZE=4, AMARGIN=4, DEPTH=16)
REQ-030 Reset then idle -> empty=1, almost_empty=1, full=0, half_full=0, almost_full=0.
REQ-031 Write 0x11, 0x22, 0x33 on consecutive cycles -> next cycle dout=0x11, empty=0, almost_empty=1; pop three times -> dout 0x22, 0x33, then empty=1.
REQ-032 Write 16 words 0x00..0x0F -> almost_empty clears at count 5, half_full sets at count 8, almost_full at count 12, full at count 16; 17th write 0xFF dropped; 16 pops return 0x00..0x0F in order.
REQ-033 Count=5, wr=1 and rd=1 with din=0xAA for 20 cycles -> count stays 5, pointers wrap past 15, output order preserved, last popped words 0xAA.
REQ-034 Full FIFO, wr=1 rd=1 din=0x77 -> count 15, full=0, 0x77 never appears; empty FIFO, rd=1 wr=1 din=0x55 -> count 1, dout=0x55.
REQ-035 Count=10, assert reset together with wr=1 -> next cycle empty=1, count 0; subsequent write 0x99 -> dout=0x99.
